// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared types and constants for the PSRAM arbiter.
// Holds the arbiter state enum and the arbitration mode encodings.
package psram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      RECOVER,
      WAIT_DONE,
      DONE
   } ArbState;

   localparam logic [1:0] ARB_FIXED0 = 2'd0;
   localparam logic [1:0] ARB_FIXED1 = 2'd1;
   localparam logic [1:0] ARB_RR     = 2'd2;

endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: requester ports 0/1 plus the memory controller link.
// slave = arbiter side, master = requester/controller side.
interface psram_arbiter_if;

   logic        i_req0;
   logic        i_req1;
   logic        i_write0;
   logic        i_write1;
   logic [23:0] i_address0;
   logic [23:0] i_address1;
   logic        i_bank0;
   logic        i_bank1;
   logic [7:0]  i_data0;
   logic [7:0]  i_data1;
   logic        o_ack0;
   logic        o_ack1;
   logic [7:0]  o_data0;
   logic [7:0]  o_data1;
   logic        o_err;
   logic [1:0]  o_grant;
   logic        o_mem_cs;
   logic        o_mem_write;
   logic [23:0] o_mem_address;
   logic        o_mem_bank;
   logic [7:0]  o_mem_data;
   logic        i_mem_busy;
   logic [7:0]  i_mem_dataRead;

   modport slave (
      input  i_req0, i_req1, i_write0, i_write1,
      input  i_address0, i_address1, i_bank0, i_bank1,
      input  i_data0, i_data1, i_mem_busy, i_mem_dataRead,
      output o_ack0, o_ack1, o_data0, o_data1, o_err, o_grant,
      output o_mem_cs, o_mem_write, o_mem_address,
      output o_mem_bank, o_mem_data
   );

   modport master (
      output i_req0, i_req1, i_write0, i_write1,
      output i_address0, i_address1, i_bank0, i_bank1,
      output i_data0, i_data1, i_mem_busy, i_mem_dataRead,
      input  o_ack0, o_ack1, o_data0, o_data1, o_err, o_grant,
      input  o_mem_cs, o_mem_write, o_mem_address,
      input  o_mem_bank, o_mem_data
   );

endinterface

// File: rtl/psram_arb_pick.sv
// psram_arb_pick: combinational 2-way picker, one-hot grant out.
// Ports: mode, last (1 = port 1 granted last), req0/req1, grant.
module psram_arb_pick
   import psram_arb_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       last,
   input  logic       req0,
   input  logic       req1,
   output logic [1:0] grant
);

   always_comb begin
      grant = {req1 & ~req0, req0};
      if (req0 && req1) begin
         unique case (1'b1)
            (mode == ARB_FIXED0): grant = 2'b01;
            (mode == ARB_FIXED1): grant = 2'b10;
            (mode == ARB_RR):     grant = last ? 2'b01 : 2'b10;
            default:              grant = 2'b01;
         endcase
      end
   end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PSRAM controller between port 0 (CPU) and port 1.
// Ports: i_clkRAM, reset (async, active-low), bus (requesters + controller).
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter int ARB_MODE       = 2,
   parameter int ACCEPT_TIMEOUT = 8,
   parameter int MAX_RETRIES    = 3
) (
   input  logic           i_clkRAM,
   input  logic           reset,
   psram_arbiter_if.slave bus
);

   localparam int            TW       = $clog2(ACCEPT_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACCEPT_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_SAT  = TW'(ACCEPT_TIMEOUT);
   localparam logic [1:0]    RTY_MAX  = 2'(MAX_RETRIES);
   localparam logic [1:0]    MODE     = 2'(ARB_MODE);

   ArbState       state_q;
   ArbState       state_d;
   logic [TW-1:0] tmo_q;
   logic [1:0]    rty_q;
   logic          last_q;
   logic [1:0]    grant_q;
   logic [1:0]    pick;

   psram_arb_pick u_pick (
      .mode  (MODE),
      .last  (last_q),
      .req0  (bus.i_req0),
      .req1  (bus.i_req1),
      .grant (pick)
   );

   // cs decodes straight from the state register, so an async
   // reset deasserts it without waiting for a clock edge.
   assign bus.o_mem_cs = (state_q != ISSUE);
   assign bus.o_grant  = grant_q;

   always_ff @(posedge i_clkRAM or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (!bus.i_mem_busy && (bus.i_req0 || bus.i_req1))
               state_d = ISSUE;
         ISSUE:
            if (bus.i_mem_busy)         state_d = WAIT_DONE;
            else if (tmo_q >= TMO_LAST) state_d = RECOVER;
         // tmo_q doubles as the 2-cycle cs-high hold here
         RECOVER:
            if (tmo_q != '0)
               state_d = (rty_q < RTY_MAX) ? ISSUE : IDLE;
         WAIT_DONE:
            if (!bus.i_mem_busy) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clkRAM or negedge reset) begin
      if (!reset) begin
         tmo_q             <= '0;
         rty_q             <= '0;
         last_q            <= 1'b1;
         grant_q           <= 2'b00;
         bus.o_ack0        <= 1'b0;
         bus.o_ack1        <= 1'b0;
         bus.o_err         <= 1'b0;
         bus.o_data0       <= '0;
         bus.o_data1       <= '0;
         bus.o_mem_write   <= 1'b0;
         bus.o_mem_address <= '0;
         bus.o_mem_bank    <= 1'b0;
         bus.o_mem_data    <= '0;
      end else begin
         bus.o_ack0 <= 1'b0;
         bus.o_ack1 <= 1'b0;
         bus.o_err  <= 1'b0;
         if (state_d != state_q) tmo_q <= '0;
         else if (tmo_q != TMO_SAT) tmo_q <= tmo_q + 1'b1;
         case (state_q)
            IDLE:
               if (state_d == ISSUE) begin
                  grant_q <= pick;
                  if (pick[1]) begin
                     bus.o_mem_write   <= bus.i_write1;
                     bus.o_mem_address <= bus.i_address1;
                     bus.o_mem_bank    <= bus.i_bank1;
                     bus.o_mem_data    <= bus.i_data1;
                  end else begin
                     bus.o_mem_write   <= bus.i_write0;
                     bus.o_mem_address <= bus.i_address0;
                     bus.o_mem_bank    <= bus.i_bank0;
                     bus.o_mem_data    <= bus.i_data0;
                  end
               end
            ISSUE:
               if (state_d == RECOVER) rty_q <= rty_q + 1'b1;
            RECOVER:
               if (state_d == IDLE) begin
                  bus.o_err <= 1'b1;
                  grant_q   <= 2'b00;
                  rty_q     <= '0;
               end
            WAIT_DONE:
               if (state_d == DONE) begin
                  bus.o_ack0 <= grant_q[0];
                  bus.o_ack1 <= grant_q[1];
                  if (!bus.o_mem_write && grant_q[0])
                     bus.o_data0 <= bus.i_mem_dataRead;
                  if (!bus.o_mem_write && grant_q[1])
                     bus.o_data1 <= bus.i_mem_dataRead;
                  last_q  <= grant_q[1];
                  grant_q <= 2'b00;
                  rty_q   <= '0;
               end
            default: ;
         endcase
      end
   end

endmodule
